net_bus_port_fifo: RTL

NET_BUS_PORT_FIFO -- requirements
Module: net_bus_port_fifo

---
 rtl/net_bus_pkg.sv | 19 +
 rtl/net_bus_fifo_ram.sv | 38 +++
 rtl/net_bus_port_fifo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/net_bus_pkg.sv
// -----------------------------------------------------------------------------
// net_bus_pkg
//   Shared NetBus definitions used by the port FIFO and its storage.
//   - net_bus_word_w(): bus word width for a given lane width
//                       (9 bits per lane plus a 14-bit header/route field).
//   - DROP_CNT_W      : width of the saturating overwrite counter.
//   - DROP_CNT_MAX    : saturation value of that counter.
// -----------------------------------------------------------------------------
package net_bus_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

  // Width of one NetBus word for a lane width of dw.
  function automatic int net_bus_word_w(input int dw);
    return dw * 9 + 14;
  endfunction

endpackage : net_bus_pkg

// File: rtl/net_bus_fifo_ram.sv
// -----------------------------------------------------------------------------
// net_bus_fifo_ram
//   Storage array for the NetBus port FIFO: W bits x DEPTH entries, a single
//   synchronous write port and an asynchronous (combinational) read port.
//   The array has no reset; the control logic guarantees that no entry is
//   observed before it has been written.
//
// Ports
//   i_clk    : write clock
//   i_we     : write enable, entry i_waddr takes i_wdata at the rising edge
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : contents of entry i_raddr (combinational)
// -----------------------------------------------------------------------------
module net_bus_fifo_ram #(
  parameter int W     = 50,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : net_bus_fifo_ram

// File: rtl/net_bus_port_fifo.sv
// -----------------------------------------------------------------------------
// net_bus_port_fifo
//   Per-port elastic buffer between an upstream NetBus source and the MUX
//   port. Words are stored unmodified and delivered in order.
//   REAL_TIME = 0 : lossless; WREADY drops while the buffer is full.
//   REAL_TIME = 1 : never stalls; a write into a full buffer with no read
//                   overwrites the oldest entry and bumps DROP_CNT.
//
// Ports
//   CLK      : sole clock, rising edge
//   RESET    : asynchronous, active-high reset
//   WDATA    : upstream bus word (W = DATA_WIDTH*9+14 bits)
//   WVALID   : WDATA valid
//   WREADY   : buffer accepts WDATA this cycle (state-driven only)
//   RDATA    : oldest stored word
//   RVALID   : RDATA valid (LEVEL != 0)
//   RREADY   : MUX port consumes RDATA
//   LEVEL    : occupancy, 0..FIFO_DEPTH
//   DROP_CNT : number of overwritten words, saturating
// -----------------------------------------------------------------------------
module net_bus_port_fifo
  import net_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int REAL_TIME  = 0
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [net_bus_word_w(DATA_WIDTH)-1:0] WDATA,
  input  logic                                 WVALID,
  output logic                                 WREADY,
  output logic [net_bus_word_w(DATA_WIDTH)-1:0] RDATA,
  output logic                                 RVALID,
  input  logic                                 RREADY,
  output logic [$clog2(FIFO_DEPTH):0]          LEVEL,
  output logic [DROP_CNT_W-1:0]                DROP_CNT
);

  localparam int W  = net_bus_word_w(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  // Set at the first edge after reset release; holds WREADY low in reset.
  logic                  r_wr_en;

  logic w_full;
  logic w_empty;
  logic w_wready;
  logic w_wr;
  logic w_rd;
  logic w_ovw;

  // Full/empty come from the occupancy count, never from pointer equality,
  // so WREADY is a pure function of registered state.
  assign w_full   = (r_level == FULL_LVL);
  assign w_empty  = (r_level == '0);
  assign w_wready = r_wr_en && ((REAL_TIME != 0) || !w_full);

  assign w_wr = WVALID && w_wready;
  assign w_rd = !w_empty && RREADY;
  // Only possible in real-time mode; a concurrent read frees the slot instead.
  assign w_ovw = w_wr && w_full && !w_rd;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wptr <= '0;
    end else if (w_wr) begin
      r_wptr <= r_wptr + AW'(1);
    end
  end

  // An overwrite discards the oldest entry, so the read side moves as well.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rptr <= '0;
    end else if (w_rd || w_ovw) begin
      r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_level <= '0;
    end else if (w_wr && !w_rd && !w_full) begin
      r_level <= r_level + LW'(1);
    end else if (w_rd && !w_wr) begin
      r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_drop_cnt <= '0;
    end else if (w_ovw && (r_drop_cnt != DROP_CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  net_bus_fifo_ram #(
    .W     (W),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (WDATA),
    .i_raddr (r_rptr),
    .o_rdata (RDATA)
  );

  assign WREADY   = w_wready;
  assign RVALID   = !w_empty;
  assign LEVEL    = r_level;
  assign DROP_CNT = r_drop_cnt;

endmodule : net_bus_port_fifo
